// File: rtl/mic_packet_sender.sv
// mic_packet_sender: buffers microphone words in a 4-deep FIFO and
// serialises each one as a {HEADER, word} frame, MSB first, when the bus
// grants a sound-in transmit slot.
//
// Ports:
//   clk                 clock, all logic on posedge
//   rst                 synchronous active-high reset
//   mic_data[31:0]      four packed u-law bytes from the microphone stage
//   mic_data_valid      mic_data holds a complete word
//   mic_data_retrieved  one-cycle pulse on the edge after a word is captured
//   tx_slot             one-cycle grant of a transmit slot
//   tx_bit_en           advance one serial bit this cycle
//   tx_data             serial frame bit, MSB first
//   tx_active           frame in progress
//   fifo_level[2:0]     words buffered, 0..4
//
// Parameter HEADER: frame marker byte sent ahead of each word.
// Build option MIC_PACKET_PARITY_EN: appends an even-parity bit over the
// 32 data bits, making the frame 41 bits instead of 40.

module mic_packet_sender #(
    parameter logic [7:0] HEADER = 8'hC7
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] mic_data,
    input  logic        mic_data_valid,
    output logic        mic_data_retrieved,
    input  logic        tx_slot,
    input  logic        tx_bit_en,
    output logic        tx_data,
    output logic        tx_active,
    output logic [2:0]  fifo_level
);

`ifdef MIC_PACKET_PARITY_EN
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        PARITY = 2'd2
    } state_e;
`else
    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_e;
`endif

    localparam logic [5:0] LAST_IDX = 6'd39;

    // FIFO storage and bookkeeping
    logic [31:0] mem_q [4];
    logic [31:0] mem_d [4];
    logic [1:0]  wr_ptr_q, wr_ptr_d;
    logic [1:0]  rd_ptr_q, rd_ptr_d;
    logic [2:0]  level_q, level_d;

    // Capture handshake
    logic        retrieved_q, retrieved_d;
    logic [1:0]  lock_q, lock_d;

    // Serialiser
    state_e      state_q, state_d;
    logic [39:0] frame_q, frame_d;
    logic [5:0]  idx_q, idx_d;
`ifdef MIC_PACKET_PARITY_EN
    logic        parity_q, parity_d;
`endif

    logic        capture;
    logic        pop;

    // Full is judged on the registered level only, so a pop in the same
    // cycle never opens room for a capture at level 4. The lockout counter
    // covers the pulse cycle plus two more, so a valid left asserted while
    // the producer reacts to the pulse is not taken twice.
    always_comb begin
        capture = mic_data_valid
                  && (level_q != 3'd4)
                  && (lock_q == 2'd0);
    end

    always_comb begin
        retrieved_d = capture;
        lock_d      = lock_q;
        if (capture) begin
            lock_d = 2'd3;
        end else if (lock_q != 2'd0) begin
            lock_d = lock_q - 2'd1;
        end
    end

    // Serialiser next state; the head word is popped on slot acceptance
    always_comb begin
        state_d  = state_q;
        frame_d  = frame_q;
        idx_d    = idx_q;
        pop      = 1'b0;
`ifdef MIC_PACKET_PARITY_EN
        parity_d = parity_q;
`endif
        case (state_q)
            IDLE: begin
                if (tx_slot && (level_q != 3'd0)) begin
                    pop      = 1'b1;
                    frame_d  = {HEADER, mem_q[rd_ptr_q]};
                    idx_d    = 6'd0;
                    state_d  = SHIFT;
`ifdef MIC_PACKET_PARITY_EN
                    parity_d = ^mem_q[rd_ptr_q];
`endif
                end
            end
            SHIFT: begin
                if (tx_bit_en) begin
                    // Shift left so the current bit is always frame_q[39]
                    frame_d = {frame_q[38:0], 1'b0};
                    if (idx_q == LAST_IDX) begin
`ifdef MIC_PACKET_PARITY_EN
                        state_d = PARITY;
`else
                        state_d = IDLE;
`endif
                    end else begin
                        idx_d = idx_q + 6'd1;
                    end
                end
            end
`ifdef MIC_PACKET_PARITY_EN
            PARITY: begin
                if (tx_bit_en) begin
                    state_d = IDLE;
                end
            end
`endif
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // FIFO next state
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (capture) begin
            mem_d[wr_ptr_q] = mic_data;
            wr_ptr_d        = wr_ptr_q + 2'd1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 2'd1;
        end
        level_d = level_q + {2'b00, capture} - {2'b00, pop};
    end

    // Storage needs no reset; the pointers and level define its contents
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q    <= 2'd0;
            rd_ptr_q    <= 2'd0;
            level_q     <= 3'd0;
            retrieved_q <= 1'b0;
            lock_q      <= 2'd0;
            state_q     <= IDLE;
            frame_q     <= 40'd0;
            idx_q       <= 6'd0;
`ifdef MIC_PACKET_PARITY_EN
            parity_q    <= 1'b0;
`endif
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            level_q     <= level_d;
            retrieved_q <= retrieved_d;
            lock_q      <= lock_d;
            state_q     <= state_d;
            frame_q     <= frame_d;
            idx_q       <= idx_d;
`ifdef MIC_PACKET_PARITY_EN
            parity_q    <= parity_d;
`endif
        end
    end

    // Outputs
    always_comb begin
        tx_data = 1'b0;
        case (state_q)
            SHIFT: begin
                tx_data = frame_q[39];
            end
`ifdef MIC_PACKET_PARITY_EN
            PARITY: begin
                tx_data = parity_q;
            end
`endif
            default: begin
                tx_data = 1'b0;
            end
        endcase
    end

    assign tx_active          = (state_q != IDLE);
    assign mic_data_retrieved = retrieved_q;
    assign fifo_level         = level_q;

endmodule

// File: tb/tb_mic_packet_sender.sv
// Testbench for mic_packet_sender: directed scenarios plus a randomized
// phase, checked by a scoreboard against a queue-based frame model.

module tb_mic_packet_sender;

    localparam logic [7:0] HDR = 8'hC7;
`ifdef MIC_PACKET_PARITY_EN
    localparam int FLEN = 41;
`else
    localparam int FLEN = 40;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] mic_data = 32'd0;
    logic        mic_data_valid = 1'b0;
    logic        mic_data_retrieved;
    logic        tx_slot = 1'b0;
    logic        tx_bit_en = 1'b0;
    logic        tx_data;
    logic        tx_active;
    logic [2:0]  fifo_level;

    always #5 clk = ~clk;

    mic_packet_sender #(.HEADER(HDR)) dut (
        .clk                (clk),
        .rst                (rst),
        .mic_data           (mic_data),
        .mic_data_valid     (mic_data_valid),
        .mic_data_retrieved (mic_data_retrieved),
        .tx_slot            (tx_slot),
        .tx_bit_en          (tx_bit_en),
        .tx_data            (tx_data),
        .tx_active          (tx_active),
        .fifo_level         (fifo_level)
    );

    int errors = 0;
    int checks = 0;

    // Reference model: words accepted but not yet sent, frames owed
    logic [31:0] mdl_fifo[$];
    logic [40:0] exp_q[$];
    bit          busy = 0;
    bit          was_busy;
    int          nbits = 0;
    logic [40:0] got = '0;
    logic [31:0] prev_mic = '0;
    bit          prev_hold = 0;
    logic        prev_tx = 1'b0;
    int          pulses = 0;
    int          frames = 0;
    bit          a_done = 0;

    function automatic logic [40:0] frame_of(input logic [31:0] w);
`ifdef MIC_PACKET_PARITY_EN
        return {HDR, w, ^w};
`else
        return {1'b0, HDR, w};
`endif
    endfunction

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask

    task automatic fail(input string name, input string msg);
        checks++;
        errors++;
        $display("FAIL %s: %s", name, msg);
    endtask

    // Monitor / scoreboard, sampled on the falling edge
    always @(negedge clk) begin
        if (rst) begin
            mdl_fifo.delete();
            exp_q.delete();
            busy      = 0;
            nbits     = 0;
            got       = '0;
            prev_hold = 0;
        end else begin
            was_busy = busy;
            if (mic_data_retrieved) begin
                pulses++;
                mdl_fifo.push_back(prev_mic);
                check("fifo_overflow", 64'(mdl_fifo.size() > 4), 64'd0);
            end
            check("fifo_level", 64'(fifo_level), 64'(mdl_fifo.size()));
            check("tx_active", 64'(tx_active), 64'(was_busy));
            if (!was_busy) begin
                check("tx_idle_zero", 64'(tx_data), 64'd0);
            end
            if (prev_hold && was_busy) begin
                check("tx_hold", 64'(tx_data), 64'(prev_tx));
            end
            prev_hold = was_busy && !tx_bit_en;
            prev_tx   = tx_data;
            if (was_busy && tx_bit_en) begin
                got = {got[39:0], tx_data};
                nbits++;
                if (nbits == FLEN) begin
                    if (exp_q.size() == 0) begin
                        fail("frame_unexpected",
                             $sformatf("got %h with no frame owed", got));
                    end else begin
                        check("frame", 64'(got), 64'(exp_q.pop_front()));
                    end
                    frames++;
                    busy  = 0;
                    nbits = 0;
                    got   = '0;
                end
            end
            if (!was_busy && tx_slot && mdl_fifo.size() > 0) begin
                exp_q.push_back(frame_of(mdl_fifo.pop_front()));
                busy = 1;
            end
        end
        prev_mic = mic_data;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic offer(input logic [31:0] w, input int budget);
        int n;
        n = 0;
        mic_data       = w;
        mic_data_valid = 1'b1;
        while (1) begin
            step();
            n++;
            if (mic_data_retrieved) break;
            if (n >= budget) begin
                fail("offer_timeout", $sformatf("word %h not taken", w));
                break;
            end
        end
        mic_data_valid = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int n;
        n = 0;
        do begin
            step();
            n++;
        end while (tx_active && n < budget);
        if (tx_active) begin
            fail("idle_timeout", $sformatf("still active after %0d", n));
        end
    endtask

    task automatic send_one();
        tx_bit_en = 1'b1;
        tx_slot   = 1'b1;
        step();
        tx_slot = 1'b0;
        wait_idle(100);
    endtask

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int p0;
        int f0;
        int n;
        logic [31:0] w;

        // Reset, then a held valid word
        repeat (3) step();
        rst = 1'b0;
        check("reset_level", 64'(fifo_level), 64'd0);
        check("reset_active", 64'(tx_active), 64'd0);
        check("reset_txdata", 64'(tx_data), 64'd0);
        check("reset_retrieved", 64'(mic_data_retrieved), 64'd0);
        p0 = pulses;
        mic_data       = 32'h11223344;
        mic_data_valid = 1'b1;
        repeat (4) step();
        mic_data_valid = 1'b0;
        repeat (3) step();
        check("s1_pulses", 64'(pulses - p0), 64'd1);
        check("s1_level", 64'(fifo_level), 64'd1);

        // One frame with tx_bit_en tied high
        f0 = frames;
        send_one();
        check("s2_frames", 64'(frames - f0), 64'd1);
        check("s2_level", 64'(fifo_level), 64'd0);

        // Five words offered, no slot: fifth stays pending
        p0 = pulses;
        for (int i = 0; i < 4; i++) offer($urandom, 20);
        mic_data       = $urandom;
        mic_data_valid = 1'b1;
        repeat (10) step();
        check("s3_pulses", 64'(pulses - p0), 64'd4);
        check("s3_level_full", 64'(fifo_level), 64'd4);
        tx_bit_en = 1'b1;
        tx_slot   = 1'b1;
        step();
        tx_slot = 1'b0;
        n = 0;
        while (!mic_data_retrieved && n < 10) begin
            step();
            n++;
        end
        mic_data_valid = 1'b0;
        check("s3_fifth_taken", 64'(mic_data_retrieved), 64'd1);
        wait_idle(100);
        check("s3_level_after", 64'(fifo_level), 64'd4);
        n = 0;
        while (fifo_level != 3'd0 && n < 8) begin
            send_one();
            n++;
        end
        check("s3_drained", 64'(fifo_level), 64'd0);

        // Same word as before, with tx_bit_en alternating
        offer(32'h11223344, 20);
        f0 = frames;
        tx_bit_en = 1'b0;
        tx_slot   = 1'b1;
        step();
        tx_slot   = 1'b0;
        tx_bit_en = 1'b1;
        n = 0;
        while (tx_active && n < 120) begin
            step();
            tx_bit_en = ~tx_bit_en;
            n++;
        end
        check("s4_frames", 64'(frames - f0), 64'd1);

        // Reset at bit 17 with a second word queued
        offer($urandom, 20);
        offer($urandom, 20);
        tx_bit_en = 1'b1;
        tx_slot   = 1'b1;
        step();
        tx_slot = 1'b0;
        repeat (17) step();
        f0  = frames;
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("s5_txdata", 64'(tx_data), 64'd0);
        check("s5_active", 64'(tx_active), 64'd0);
        check("s5_level", 64'(fifo_level), 64'd0);
        tx_slot = 1'b1;
        step();
        tx_slot = 1'b0;
        repeat (45) step();
        check("s5_no_frame", 64'(frames - f0), 64'd0);

        // Parity boundary words
        offer(32'h00000001, 20);
        send_one();
        offer(32'h00000003, 20);
        send_one();

        // Randomized traffic
        fork
            begin
                for (int i = 0; i < 30; i++) begin
                    w = $urandom;
                    offer(w, 400);
                    repeat ($urandom_range(0, 3)) step();
                end
                a_done = 1;
            end
            begin
                n = 0;
                while (!a_done && n < 20000) begin
                    tx_bit_en = 1'($urandom_range(0, 1));
                    tx_slot   = ($urandom_range(0, 7) == 0);
                    step();
                    n++;
                end
                tx_slot = 1'b0;
            end
        join

        // Drain everything left
        tx_bit_en = 1'b1;
        n = 0;
        while ((fifo_level != 3'd0 || tx_active) && n < 1000) begin
            tx_slot = !tx_active;
            step();
            n++;
        end
        tx_slot = 1'b0;
        repeat (3) step();
        check("final_level", 64'(fifo_level), 64'd0);
        check("final_owed", 64'(exp_q.size()), 64'd0);
        check("final_model", 64'(mdl_fifo.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mic_packet_sender.md
MIC_PACKET_SENDER -- requirements
Module: mic_packet_sender

Interface
REQ-001 SHALL have ports (name, direction, width, meaning):
- clk  in  1  mon clock; all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- mic_data  in  32  four packed u-law bytes from the microphone stage.
- mic_data_valid  in  1  mic_data holds a complete word.
- mic_data_retrieved  out  1  one-cycle pulse: word captured.
- tx_slot  in  1  one-cycle pulse: bus grants a sound-in transmit slot.
- tx_bit_en  in  1  advance one serial bit this cycle.
- tx_data  out  1  serial frame bit, MSB first.
- tx_active  out  1  frame in progress.
- fifo_level  out  3  words buffered, 0..4.

REQ-002 SHALL have parameter HEADER, default 8'hC7, meaning the sound-in frame marker byte.

Function
REQ-003 SHALL buffer words in a 4-entry FIFO; fifo_level SHALL be registered and exact.
REQ-004 SHALL capture mic_data into the FIFO in a cycle where mic_data_valid=1, fifo_level<4 and no lockout is active; mic_data_retrieved SHALL be high for exactly that capture cycle plus one registered cycle of latency, i.e. a single pulse on the following edge.
REQ-005 SHALL hold a 2-cycle lockout after each retrieved pulse, ignoring mic_data_valid, so a stale valid is not captured twice.
REQ-006 SHALL compute "full" from the registered fifo_level, so no capture occurs at level 4 even when a pop happens in the same cycle.
REQ-007 SHALL implement states IDLE and SHIFT, plus PARITY under REQ-016.
REQ-008 IDLE -> SHIFT SHALL occur when tx_slot=1 and fifo_level>0: pop the head word, load the frame {HEADER, word}, clear the bit index, and set tx_active=1 on the next edge.
REQ-009 tx_slot in IDLE with an empty FIFO, and any tx_slot while in SHIFT or PARITY, SHALL be ignored with no queuing.
REQ-010 In SHIFT, tx_data SHALL present frame bit [39-index]; each cycle with tx_bit_en=1 SHALL increment index; tx_bit_en=0 SHALL hold tx_data and index.
REQ-011 After the enabled cycle at index 39, the next state SHALL be IDLE (or PARITY); tx_data=0 and tx_active=0 SHALL hold in IDLE.
REQ-012 A simultaneous capture and pop SHALL leave fifo_level unchanged, and FIFO order SHALL be strict first-in first-out.
REQ-013 Read and write pointers SHALL be 2-bit and wrap 3->0.

Reset
REQ-014 While rst=1, on each clk edge the block SHALL set: state=IDLE, FIFO flushed, fifo_level=0, tx_data=0, tx_active=0, mic_data_retrieved=0, lockout cleared.
REQ-015 A reset asserted mid-frame SHALL abort the frame on that edge, and the discarded word SHALL not be retransmitted.

Configuration
REQ-016 With MIC_PACKET_PARITY_EN defined:
- after bit 39, the block SHALL enter PARITY and drive the even parity of the 32 data bits for one tx_bit_en cycle, then go to IDLE.
- The frame SHALL be 41 bits.
Without the macro, the frame SHALL be 40 bits and no PARITY state SHALL exist.

Verification
REQ-017 Bench SHALL cover:
- Reset, then mic_data=32'h11223344 held valid. Response: one retrieved pulse, fifo_level=1, no second capture during lockout.
- tx_slot with tx_bit_en tied high. Response: tx_data sequence C7,11,22,33,44 MSB first over 40 cycles, then tx_active=0 and fifo_level=0.
- Five words offered with no tx_slot. Response: exactly 4 retrieved pulses, fifo_level=4, valid left pending; then tx_slot pops a word and the 5th is captured.
- tx_bit_en toggled 1010 during a frame. Response: 80 cycles, tx_data held on disabled cycles, output identical to the previous scenario.
- rst pulse at bit 17. Response: tx_data=0, tx_active=0, fifo_level=0 next edge; a later tx_slot emits nothing.
- With MIC_PACKET_PARITY_EN and word 32'h00000001. Response: 41st bit=1; with 32'h00000003 the 41st bit=0.
